multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Sequencing FSM for the multi-cycle MIPS datapath: one shared memory, one ALU, IR/A/B/ALUOut registers.
//  Steps each instruction through fetch/decode/execute/memory/writeback, handshaking with variable-latency memory.
//  Supports add/and/or/sub, lw, sw, addi, andi, beq. Unsupported encodings and memory timeouts enter TRAP.
// PARAMETERS
//  MEM_TIMEOUT    16  max cycles a memory state waits for mem_ready before bus error; 0 = wait forever
//  RETIRED_WIDTH  32  width of retired-instruction counter
// PORTS
//  clk                            in   1   clock, all state on rising edge
//  reset_n                        in   1   asynchronous active-low reset
//  instruction                    in   32  current IR contents
//  mem_ready                      in   1   memory has completed the requested access this cycle
//  alu_zero                       in   1   ALU result == 0
//  mem_request                    out  1   memory access requested; held until mem_ready
//  mem_write_enable               out  1   access is a write (valid with mem_request)
//  mem_address_source             out  1   0 = PC, 1 = ALUOut
//  instruction_register_write     out  1   load IR from memory read data
//  pc_write_enable                out  1   load PC this edge
//  pc_source                      out  1   0 = ALU result, 1 = ALUOut
//  alu_a_source                   out  1   0 = PC, 1 = register A
//  alu_b_source                   out  2   00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//  alu_ctrl                       out  3   000 and, 001 or, 010 add, 110 sub
//  register_write_enable          out  1   write register file this edge
//  register_write_address_source  out  1   0 = rt, 1 = rd
//  register_write_data_source     out  1   0 = ALUOut, 1 = memory data register
//  state                          out  4   current FSM state (debug)
//  illegal_instruction            out  1   sticky: TRAP entered on bad opcode/funct
//  bus_error                      out  1   sticky: TRAP entered on memory timeout
//  retired_count                  out  RETIRED_WIDTH  instructions completed, wraps modulo 2^RETIRED_WIDTH
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC_R=2 WB_R=3 MEM_ADDR=4 MEM_READ=5 WB_MEM=6 MEM_WRITE=7
//          EXEC_I=8 WB_I=9 BRANCH=10 TRAP=15. Unused codes go to TRAP.
//  Reset (async, reset_n low): state=FETCH, counters 0, flags 0. All outputs forced 0 while reset_n low.
//  Outputs are decoded from state; enables qualified by mem_ready/alu_zero where noted; unlisted outputs 0.
//  FETCH: mem_request=1, addr=PC, alu_a=PC, alu_b=4, add. When mem_ready: IR write=1, pc_write=1,
//    pc_source=0, -> DECODE. Otherwise stay.
//  DECODE: alu_a=PC, alu_b=11, add (branch target -> ALUOut). Next by opcode:
//    000000 with funct 100000/100100/100101/100010 -> EXEC_R; 100011/101011 -> MEM_ADDR;
//    001000/001100 -> EXEC_I; 000100 -> BRANCH; anything else -> TRAP, set illegal_instruction.
//  EXEC_R: alu_a=A, alu_b=B, alu_ctrl per funct (add 010, and 000, or 001, sub 110) -> WB_R.
//  WB_R: reg write, address=rd, data=ALUOut -> FETCH.
//  MEM_ADDR: alu_a=A, alu_b=10, add. -> MEM_READ if lw, MEM_WRITE if sw.
//  MEM_READ: mem_request=1, addr=ALUOut; mem_ready -> WB_MEM.
//  WB_MEM: reg write, address=rt, data=memory -> FETCH.
//  MEM_WRITE: mem_request=1, mem_write_enable=1, addr=ALUOut; mem_ready -> FETCH.
//  EXEC_I: alu_a=A, alu_b=10, alu_ctrl 010 (addi) or 000 (andi) -> WB_I. WB_I: write rt from ALUOut -> FETCH.
//  BRANCH: alu_a=A, alu_b=B, sub, pc_source=1, pc_write_enable=alu_zero -> FETCH.
//  TRAP: all control outputs 0; absorbing until reset.
//  Retire: retired_count += 1 on each edge leaving WB_R, WB_MEM, MEM_WRITE(ready), WB_I, BRANCH.
//  Timeout: wait counter cleared on entering any memory state, +1 per cycle with mem_ready low.
//    When count reaches MEM_TIMEOUT-1 and mem_ready is still low -> TRAP, set bus_error.
//    mem_ready in the same cycle as the final count wins (normal advance). MEM_TIMEOUT=0: never times out.
//  mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored. Reset mid-instruction abandons it, no write issued.
//  Zero-wait latencies (cycles): R-type 4, addi/andi 4, lw 5, sw 4, beq 3; each wait cycle adds 1.
// TESTING
//  add $3,$1,$2 (0x00221820), mem_ready always 1 -> states 0,1,2,3; WB_R reg write, rd select; retired 0->1.
//  lw, mem_ready low 3 cycles in FETCH and 2 in MEM_READ -> 10 cycles total; single IR write, single reg write.
//  beq, alu_zero=1 then repeat with alu_zero=0 -> pc_write_enable in BRANCH 1 vs 0; 3 cycles each.
//  opcode 6'b111111 or R-type funct 100111 -> TRAP after DECODE; illegal_instruction=1; no reg/mem writes after.
//  MEM_TIMEOUT=4, mem_ready never rises in MEM_WRITE -> TRAP after 4 cycles, bus_error=1; ready on 4th -> FETCH.
//  reset_n low mid-MEM_WRITE -> outputs 0 immediately; after release state=FETCH, counters and flags 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing FSM for a multi-cycle MIPS datapath with a variable-latency memory handshake.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned RETIRED_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              instruction,
  input  logic                     mem_ready,
  input  logic                     alu_zero,
  output logic                     mem_request,
  output logic                     mem_write_enable,
  output logic                     mem_address_source,
  output logic                     instruction_register_write,
  output logic                     pc_write_enable,
  output logic                     pc_source,
  output logic                     alu_a_source,
  output logic [1:0]               alu_b_source,
  output logic [2:0]               alu_ctrl,
  output logic                     register_write_enable,
  output logic                     register_write_address_source,
  output logic                     register_write_data_source,
  output logic [3:0]               state,
  output logic                     illegal_instruction,
  output logic                     bus_error,
  output logic [RETIRED_WIDTH-1:0] retired_count
);

  localparam int unsigned WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SUB = 6'b100010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_WB_MEM    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_EXEC_I    = 4'd8,
    S_WB_I      = 4'd9,
    S_BRANCH    = 4'd10,
    S_TRAP      = 4'd15
  } state_e;

  state_e                   state_q, state_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     illegal_q, bus_error_q;
  logic [RETIRED_WIDTH-1:0] retired_q;
  logic                     illegal_set_c, bus_set_c, retire_c;
  logic                     timeout_c, mem_state_c, funct_ok_c;
  logic [5:0]               opcode, funct;
  logic                     unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[25:6];
  assign funct_ok_c        = (funct == FN_ADD) || (funct == FN_AND) ||
                             (funct == FN_OR)  || (funct == FN_SUB);
  assign mem_state_c       = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                             (state_q == S_MEM_WRITE);
  assign timeout_c         = TIMEOUT_EN && mem_state_c && !mem_ready && (wait_q == WAIT_LAST);

  // State and memory-wait counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, wait counter, retire and trap-cause decode
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    illegal_set_c = 1'b0;
    bus_set_c     = 1'b0;
    retire_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timeout_c) begin state_d = S_TRAP; bus_set_c = 1'b1; end
      end
      S_DECODE: begin
        if (opcode == OP_RTYPE && funct_ok_c)          state_d = S_EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW)     state_d = S_MEM_ADDR;
        else if (opcode == OP_ADDI || opcode == OP_ANDI) state_d = S_EXEC_I;
        else if (opcode == OP_BEQ)                       state_d = S_BRANCH;
        else begin
          state_d       = S_TRAP;
          illegal_set_c = 1'b1;
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     begin state_d = S_FETCH; retire_c = 1'b1; end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)      state_d = S_WB_MEM;
        else if (timeout_c) begin state_d = S_TRAP; bus_set_c = 1'b1; end
      end
      S_WB_MEM:   begin state_d = S_FETCH; retire_c = 1'b1; end
      S_MEM_WRITE: begin
        if (mem_ready)      begin state_d = S_FETCH; retire_c = 1'b1; end
        else if (timeout_c) begin state_d = S_TRAP; bus_set_c = 1'b1; end
      end
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     begin state_d = S_FETCH; retire_c = 1'b1; end
      S_BRANCH:   begin state_d = S_FETCH; retire_c = 1'b1; end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    // Counter restarts on every state change, counts idle cycles in memory states
    if (state_d != state_q) wait_d = '0;
    else if (mem_state_c)   wait_d = wait_q + WAIT_W'(1);
  end

  // Datapath control decode from current state; all forced low during reset
  always_comb begin
    mem_request                   = 1'b0;
    mem_write_enable              = 1'b0;
    mem_address_source            = 1'b0;
    instruction_register_write    = 1'b0;
    pc_write_enable               = 1'b0;
    pc_source                     = 1'b0;
    alu_a_source                  = 1'b0;
    alu_b_source                  = 2'b00;
    alu_ctrl                      = ALU_AND;
    register_write_enable         = 1'b0;
    register_write_address_source = 1'b0;
    register_write_data_source    = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_request                = 1'b1;
          alu_b_source               = 2'b01;
          alu_ctrl                   = ALU_ADD;
          instruction_register_write = mem_ready;
          pc_write_enable            = mem_ready;
        end
        S_DECODE: begin
          alu_b_source = 2'b11;
          alu_ctrl     = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_a_source = 1'b1;
          case (funct)
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SUB:  alu_ctrl = ALU_SUB;
            default: alu_ctrl = ALU_ADD;
          endcase
        end
        S_WB_R: begin
          register_write_enable         = 1'b1;
          register_write_address_source = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_a_source = 1'b1;
          alu_b_source = 2'b10;
          alu_ctrl     = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_request        = 1'b1;
          mem_address_source = 1'b1;
        end
        S_WB_MEM: begin
          register_write_enable      = 1'b1;
          register_write_data_source = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_request        = 1'b1;
          mem_write_enable   = 1'b1;
          mem_address_source = 1'b1;
        end
        S_EXEC_I: begin
          alu_a_source = 1'b1;
          alu_b_source = 2'b10;
          alu_ctrl     = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        end
        S_WB_I:   register_write_enable = 1'b1;
        S_BRANCH: begin
          alu_a_source    = 1'b1;
          alu_ctrl        = ALU_SUB;
          pc_source       = 1'b1;
          pc_write_enable = alu_zero;
        end
        default: ;
      endcase
    end
  end

  // Sticky trap causes and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      if (illegal_set_c) illegal_q   <= 1'b1;
      if (bus_set_c)     bus_error_q <= 1'b1;
      if (retire_c)      retired_q   <= retired_q + RETIRED_WIDTH'(1);
    end
  end

  assign state               = state_q;
  assign illegal_instruction = illegal_q;
  assign bus_error           = bus_error_q;
  assign retired_count       = retired_q;

endmodule
